bus_mem_responder: RTL and testbench
====================================

# bus_mem_responder

Memory-side responder for the CPU's data/address bus: accepts one read or write request at a time from the datapath, which drives the address from its address register and write data from its data register. After an optional fixed number of wait states it returns a single-cycle response, and `resp_valid` is wired directly as the load enable of the CPU's data or instruction register. It backs the CPU's instruction and data space in simulation and FPGA builds.

## Interface
Parameters:
- `DATA_BUS_WIDTH`, 16, width of data words.
- `ADDRESS_BUS_WIDTH`, 16, width of request address.
- `MEM_DEPTH`, 256, number of words stored; valid addresses are 0..MEM_DEPTH-1.
- `WAIT_CYCLES`, 2, wait states inserted per transaction. Used only with `MEM_RESP_WAIT_EN`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present. Held with stable fields until accepted.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDRESS_BUS_WIDTH  word address.
- `req_wdata`  in  DATA_BUS_WIDTH  write data.
- `req_ready`  out  1  responder idle and able to accept.
- `resp_valid`  out  1  one-cycle response strobe (register load enable).
- `resp_rdata`  out  DATA_BUS_WIDTH  read data, valid while `resp_valid`=1.
- `resp_err`  out  1  address out of range, valid while `resp_valid`=1.

## Operation
- FSM states IDLE, WAIT, RESP. All outputs are registered.
- Reset values: state IDLE, `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, wait counter 0. Memory contents are not reset.
- After reset: `req_ready` rises at the first rising edge after `rst` deasserts.
- IDLE: a request is accepted on an edge where `req_valid`=1 and `req_ready`=1. Address, write flag and write data are latched, and `req_ready` drops on the same edge.
  - Next state is WAIT (counter loaded with WAIT_CYCLES-1) when wait states are enabled and WAIT_CYCLES>0.
  - Otherwise next state is RESP.
- WAIT: the counter decrements each cycle. When it reaches 0, the next edge enters RESP.
- Entering RESP:
  - Read: `resp_rdata` = mem[addr].
  - Write: mem[addr] is written and `resp_rdata` = 0.
  - `resp_valid` = 1.
- RESP lasts exactly one cycle. The next edge returns to IDLE, clears `resp_valid`, `resp_err` and `resp_rdata`, and sets `req_ready`=1.
- Out-of-range access (`req_addr` >= MEM_DEPTH): no memory write, `resp_rdata`=0, `resp_err`=1. Timing is identical to an in-range access.
- Requests while `req_ready`=0 are ignored, not queued.
- Reset mid-transaction (WAIT or RESP) abandons the transaction. A write not yet committed (reset before the RESP entry edge) leaves memory unchanged.

## Timing
- Accept edge E0. `resp_valid` is high in the cycle after edge E0+W, where W = WAIT_CYCLES (wait states enabled) or 0 (disabled).
- With wait states disabled, the response is visible in the cycle immediately following the accept edge.
- `req_ready` is low from E0 until the edge ending RESP.
- Throughput is one transaction per W+2 cycles, for back-to-back requests with `req_valid` held high.
- A read immediately after a write to the same address returns the new data.

## Configuration
- `MEM_RESP_WAIT_EN` defined: WAIT state and counter (width clog2(WAIT_CYCLES+1)) compiled in. Latency is WAIT_CYCLES+1, and WAIT_CYCLES=0 degenerates to the no-wait behaviour.
- Undefined: no WAIT state or counter, WAIT_CYCLES is ignored, and latency is fixed at 1.

## Structure
- Shared parameter include: DATA_BUS_WIDTH, ADDRESS_BUS_WIDTH, new MEM_DEPTH and WAIT_CYCLES defaults, and the FSM state encodings (IDLE=0, WAIT=1, RESP=2, 2 bits).
- One sub-module, `resp_mem_array`: synchronous-write, registered-read word array (`clk`, `we`, `addr`, `wdata`, `rdata`), no reset. The FSM, range check and counter stay in `bus_mem_responder`.

## Test plan
- Reset: hold `rst` for 3 cycles mid-clock, with `req_valid`=1 throughout → all outputs 0 during reset; `req_ready`=1 one edge after release; no response occurs for the held request before that.
- Write then read, with `MEM_RESP_WAIT_EN` and WAIT_CYCLES=2: write 0xBEEF to 0x10, then read 0x10 → each `resp_valid` pulse lands 3 cycles after accept, and the read returns 0xBEEF with `resp_err`=0.
- Out of range, MEM_DEPTH=256: write 0x1234 to 0x0100, then read 0x0100 → `resp_err`=1 and `resp_rdata`=0 on both. A subsequent read of 0x0000 is unchanged.
- Busy rejection: pulse a second request during WAIT → ignored. Only the first transaction responds, and exactly one `resp_valid` pulse is seen.
- Reset during WAIT: write 0x5555 to 0x20 (old value 0x1111) and assert `rst` in WAIT → no `resp_valid`; a later read of 0x20 returns 0x1111.
- No-wait build (macro undefined): back-to-back reads of 0x00, 0x01 with `req_valid` held → `resp_valid` 1 cycle after each accept, and accepts are spaced 2 cycles apart.

Source files
------------

// File: rtl/bus_mem_responder_pkg.sv
// Shared widths, depth/wait defaults and FSM encodings for the bus memory responder.
// Consumers: bus_mem_responder and resp_mem_array.
package bus_mem_responder_pkg;

    localparam int DEF_DATA_BUS_WIDTH    = 16;
    localparam int DEF_ADDRESS_BUS_WIDTH = 16;
    localparam int DEF_MEM_DEPTH         = 256;
    localparam int DEF_WAIT_CYCLES       = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Index width that never collapses to zero bits for tiny depths/counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/resp_mem_array.sv
// Word array with synchronous write and registered read; contents are never reset.
// Read is read-first: a write edge returns the previous word.
module resp_mem_array
    import bus_mem_responder_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
    parameter int MEM_DEPTH      = DEF_MEM_DEPTH,
    localparam int MEM_AW        = clog2_min1(MEM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [MEM_AW-1:0]         addr,
    input  logic [DATA_BUS_WIDTH-1:0] wdata,
    output logic [DATA_BUS_WIDTH-1:0] rdata
);

    logic [DATA_BUS_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Single-outstanding bus memory responder: IDLE -> (WAIT) -> RESP, one-cycle response strobe.
// Define MEM_RESP_WAIT_EN to compile in the WAIT state and its countdown (WAIT_CYCLES).
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int DATA_BUS_WIDTH    = DEF_DATA_BUS_WIDTH,
    parameter int ADDRESS_BUS_WIDTH = DEF_ADDRESS_BUS_WIDTH,
    parameter int MEM_DEPTH         = DEF_MEM_DEPTH,
    parameter int WAIT_CYCLES       = DEF_WAIT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic                         req_write,
    input  logic [ADDRESS_BUS_WIDTH-1:0] req_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    req_wdata,
    output logic                         req_ready,
    output logic                         resp_valid,
    output logic [DATA_BUS_WIDTH-1:0]    resp_rdata,
    output logic                         resp_err
);

    localparam int MEM_AW = clog2_min1(MEM_DEPTH);
`ifdef MEM_RESP_WAIT_EN
    localparam int WAIT_STATES = WAIT_CYCLES;
    localparam int CNT_W       = clog2_min1(WAIT_CYCLES + 1);
`else
    // Without the wait feature the parameter has no effect on timing.
    localparam int WAIT_STATES = WAIT_CYCLES * 0;
`endif

    logic [1:0]                   state_reg, state_next;
    logic                         req_ready_reg, req_ready_next;
    logic                         resp_valid_reg, resp_valid_next;
    logic                         resp_err_reg, resp_err_next;
    logic                         resp_rd_en_reg, resp_rd_en_next;
    logic                         write_reg, write_next;
    logic [ADDRESS_BUS_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_BUS_WIDTH-1:0]    wdata_reg, wdata_next;
`ifdef MEM_RESP_WAIT_EN
    logic [CNT_W-1:0]             wait_cnt_reg, wait_cnt_next;
    logic                         wait_done;
`endif

    logic                         accept;
    logic                         resp_entry;
    logic                         use_req;
    logic                         ent_write;
    logic [ADDRESS_BUS_WIDTH-1:0] ent_addr;
    logic [DATA_BUS_WIDTH-1:0]    ent_wdata;
    logic                         ent_in_range;
    logic                         mem_we;
    logic [DATA_BUS_WIDTH-1:0]    mem_rdata;

    assign accept = (state_reg == ST_IDLE) && req_ready_reg && req_valid;

`ifdef MEM_RESP_WAIT_EN
    assign wait_done  = (state_reg == ST_WAIT) && (wait_cnt_reg == '0);
    assign resp_entry = (accept && (WAIT_STATES == 0)) || wait_done;
`else
    assign resp_entry = accept && (WAIT_STATES == 0);
`endif

    // The memory is accessed on the edge that enters RESP; from IDLE that edge is
    // the accept edge itself, so the live request fields are used instead of the latch.
    assign use_req      = (state_reg == ST_IDLE);
    assign ent_write    = use_req ? req_write : write_reg;
    assign ent_addr     = use_req ? req_addr  : addr_reg;
    assign ent_wdata    = use_req ? req_wdata : wdata_reg;
    assign ent_in_range = 32'(ent_addr) < 32'(MEM_DEPTH);
    assign mem_we       = resp_entry && ent_write && ent_in_range && !rst;

    resp_mem_array #(
        .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
        .MEM_DEPTH      (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (ent_addr[MEM_AW-1:0]),
        .wdata (ent_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_next      = state_reg;
        req_ready_next  = req_ready_reg;
        write_next      = write_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_rd_en_next = 1'b0;
`ifdef MEM_RESP_WAIT_EN
        wait_cnt_next   = wait_cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (!req_ready_reg) begin
                    req_ready_next = 1'b1;
                end else if (req_valid) begin
                    req_ready_next = 1'b0;
                    write_next     = req_write;
                    addr_next      = req_addr;
                    wdata_next     = req_wdata;
                    state_next     = ST_RESP;
`ifdef MEM_RESP_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = CNT_W'(WAIT_CYCLES - 1);
                    end
`endif
                end
            end
`ifdef MEM_RESP_WAIT_EN
            ST_WAIT: begin
                if (wait_cnt_reg == '0) begin
                    state_next = ST_RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg - CNT_W'(1);
                end
            end
`endif
            ST_RESP: begin
                state_next     = ST_IDLE;
                req_ready_next = 1'b1;
            end
            default: begin
                state_next     = ST_IDLE;
                req_ready_next = 1'b0;
            end
        endcase

        if (resp_entry) begin
            resp_valid_next = 1'b1;
            resp_err_next   = !ent_in_range;
            resp_rd_en_next = !ent_write && ent_in_range;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            req_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rd_en_reg <= 1'b0;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
`ifdef MEM_RESP_WAIT_EN
            wait_cnt_reg   <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            req_ready_reg  <= req_ready_next;
            resp_valid_reg <= resp_valid_next;
            resp_err_reg   <= resp_err_next;
            resp_rd_en_reg <= resp_rd_en_next;
            write_reg      <= write_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
`ifdef MEM_RESP_WAIT_EN
            wait_cnt_reg   <= wait_cnt_next;
`endif
        end
    end

    // Read data comes straight from the array's output register, qualified by a
    // registered enable so writes, errors and idle cycles present zero.
    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rd_en_reg ? mem_rdata : '0;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: transaction-level model compared every cycle.
// Works for both builds (MEM_RESP_WAIT_EN defined or not).
module tb_bus_mem_responder;

    localparam int DW    = 16;
    localparam int AWB   = 16;
    localparam int DEPTH = 256;
    localparam int WC    = 2;
`ifdef MEM_RESP_WAIT_EN
    localparam int W = WC;
`else
    localparam int W = 0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_write = 1'b0;
    logic [AWB-1:0] req_addr = '0;
    logic [DW-1:0]  req_wdata = '0;
    logic           req_ready;
    logic           resp_valid;
    logic [DW-1:0]  resp_rdata;
    logic           resp_err;

    always #5 clk = ~clk;

    bus_mem_responder #(
        .DATA_BUS_WIDTH    (DW),
        .ADDRESS_BUS_WIDTH (AWB),
        .MEM_DEPTH         (DEPTH),
        .WAIT_CYCLES       (WC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Transaction-level model: one request in flight, response W edges after accept,
    // responder ready again one edge after the response.
    int            e = 0;
    bit            m_busy = 0;
    bit            m_ready = 0;
    bit            m_accepted = 0;
    int            m_acc = 0;
    logic          m_w = 0;
    logic [15:0]   m_a = 0;
    logic [15:0]   m_d = 0;
    logic [15:0]   mmem [DEPTH];
    logic          x_valid = 0;
    logic          x_err = 0;
    logic [15:0]   x_rdata = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_ready = 0; m_accepted = 0;
        x_valid = 0; x_err = 0; x_rdata = 0;
    endtask

    task automatic model_step();
        e++;
        m_accepted = 0;
        if (rst) begin
            model_reset();
            return;
        end
        x_valid = 0; x_err = 0; x_rdata = 0;
        if (m_busy && e == m_acc + W + 1) begin
            m_busy = 0;
            m_ready = 1;
        end else if (!m_busy) begin
            if (!m_ready) begin
                m_ready = 1;
            end else if (req_valid) begin
                m_busy = 1; m_ready = 0; m_acc = e; m_accepted = 1;
                m_w = req_write; m_a = req_addr; m_d = req_wdata;
            end
        end
        if (m_busy && e == m_acc + W) begin
            x_valid = 1;
            if (int'(m_a) >= DEPTH) x_err = 1;
            else if (m_w) mmem[m_a[7:0]] = m_d;
            else x_rdata = mmem[m_a[7:0]];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chk_en) begin
            chk("req_ready", req_ready, m_ready);
            chk("resp_valid", resp_valid, x_valid);
            chk("resp_rdata", resp_rdata, x_rdata);
            chk("resp_err", resp_err, x_err);
        end
    endtask

    task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output logic [15:0] rd, output logic er);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        lat = -1; rd = '0; er = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (m_accepted) req_valid = 0;
            if (resp_valid === 1'b1) begin
                lat = n; rd = resp_rdata; er = resp_err;
                break;
            end
        end
        req_valid = 0;
        chk("latency", lat, W + 1);
        tick();
        $display("txn %s addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 w ? "WR" : "RD", a, d, rd, er, lat);
    endtask

    initial begin
        int lat, pulses, t1, t2, nacc;
        logic [15:0] rd, r1, r2, a;
        logic er;

        // Reset held across three edges with a request pending the whole time.
        req_valid = 1; req_write = 1; req_addr = 16'h0000; req_wdata = 16'hA5A5;
        repeat (2) @(negedge clk);
        rst = 1;
        model_reset();
        chk_en = 1;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        repeat (3) begin
            tick();
            chk("rst_hold_valid", resp_valid, 0);
        end
        rst = 0;
        tick();
        chk("ready_after_rst", req_ready, 1);
        chk("no_resp_before_ready", resp_valid, 0);
        tick();
        req_valid = 0;
        repeat (W + 1) tick();

        for (int i = 0; i < DEPTH; i++) begin
            a = 16'(i);
            txn(1'b1, a, 16'($urandom), lat, rd, er);
        end

        txn(1'b1, 16'h0010, 16'hBEEF, lat, rd, er);
        chk("wr_beef_err", er, 0);
        txn(1'b0, 16'h0010, 16'h0000, lat, rd, er);
        chk("rd_beef", rd, 16'hBEEF);
        chk("rd_beef_err", er, 0);

        txn(1'b1, 16'h0100, 16'h1234, lat, rd, er);
        chk("oor_wr_err", er, 1);
        chk("oor_wr_rdata", rd, 0);
        txn(1'b0, 16'h0100, 16'h0000, lat, rd, er);
        chk("oor_rd_err", er, 1);
        chk("oor_rd_rdata", rd, 0);
        txn(1'b0, 16'h0000, 16'h0000, lat, rd, er);
        chk("oor_addr0_kept", rd, mmem[0]);
        txn(1'b1, 16'h00FF, 16'hC0DE, lat, rd, er);
        txn(1'b0, 16'h00FF, 16'h0000, lat, rd, er);
        chk("top_addr_rd", rd, 16'hC0DE);
        chk("top_addr_err", er, 0);

        // Second request pulsed while busy must be dropped.
        pulses = 0;
        req_valid = 1; req_write = 1; req_addr = 16'h0030; req_wdata = 16'h7777;
        tick();
        pulses += int'(resp_valid);
        req_addr = 16'h0031; req_wdata = 16'hDEAD;
        tick();
        pulses += int'(resp_valid);
        req_valid = 0;
        repeat (W + 4) begin
            tick();
            pulses += int'(resp_valid);
        end
        chk("busy_one_pulse", pulses, 1);
        txn(1'b0, 16'h0030, 16'h0000, lat, rd, er);
        chk("busy_first_data", rd, 16'h7777);
        txn(1'b0, 16'h0031, 16'h0000, lat, rd, er);
        chk("busy_second_ignored", rd, mmem[8'h31]);

        // Reset one cycle after accepting a write.
        txn(1'b1, 16'h0020, 16'h1111, lat, rd, er);
        req_valid = 1; req_write = 1; req_addr = 16'h0020; req_wdata = 16'h5555;
        tick();
        pulses = int'(resp_valid);
        req_valid = 0;
        rst = 1;
        model_reset();
        #1;
        chk("midrst_ready", req_ready, 0);
        chk("midrst_valid", resp_valid, 0);
        repeat (2) begin
            tick();
            pulses += int'(resp_valid);
        end
        rst = 0;
        tick();
        chk("midrst_pulses", pulses, (W == 0) ? 1 : 0);
        txn(1'b0, 16'h0020, 16'h0000, lat, rd, er);
        chk("midrst_mem", rd, (W > 0) ? 16'h1111 : 16'h5555);

        // Back-to-back reads with req_valid held.
        req_valid = 1; req_write = 0; req_addr = 16'h0000; req_wdata = 16'h0000;
        t1 = -1; t2 = -1; nacc = 0; r1 = '0; r2 = '0;
        for (int n = 1; n <= 3 * (W + 2) + 6; n++) begin
            tick();
            if (m_accepted) begin
                nacc++;
                if (nacc == 1) req_addr = 16'h0001;
                else req_valid = 0;
            end
            if (resp_valid === 1'b1) begin
                if (t1 < 0) begin t1 = n; r1 = resp_rdata; end
                else if (t2 < 0) begin t2 = n; r2 = resp_rdata; end
            end
        end
        req_valid = 0;
        chk("b2b_first_lat", t1, W + 1);
        chk("b2b_spacing", t2 - t1, W + 2);
        chk("b2b_rd0", r1, mmem[0]);
        chk("b2b_rd1", r2, mmem[1]);
        $display("txn RD b2b addr=0000/0001 rdata=%h/%h resp_ticks=%0d/%0d", r1, r2, t1, t2);

        for (int i = 0; i < 150; i++) begin
            int sel;
            repeat ($urandom_range(0, 2)) tick();
            sel = $urandom_range(0, 9);
            if (sel < 6)       a = 16'($urandom_range(0, DEPTH - 1));
            else if (sel == 6) a = 16'(DEPTH - 1);
            else if (sel == 7) a = 16'(DEPTH);
            else               a = 16'($urandom);
            txn(1'($urandom_range(0, 1)), a, 16'($urandom), lat, rd, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
